// File: rtl/dma_apb_cfg_slave.sv
// APB3/APB4 completer for the DMA channel configuration register bank.
// Optional privilege check enabled by defining DMA_APB_PROT_CHECK_EN.
module dma_apb_cfg_slave #(
  parameter int                WIDTH      = 32,
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = 'h090,
  parameter int                EXTRA_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic [WIDTH-1:0]     pwdata,
  input  logic [WIDTH/8-1:0]   pstrb,
  input  logic [2:0]           pprot,
  output logic [WIDTH-1:0]     prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 cfg_wr_en,
  output logic                 cfg_rd_en,
  output logic [WIDTH-1:0]     cfg_addr,
  output logic [WIDTH-1:0]     cfg_wdata,
  input  logic [WIDTH-1:0]     cfg_rdata
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_LOAD = (EXTRA_WAIT > 0) ? 3'(EXTRA_WAIT - 1) : 3'd0;

  state_t              state_reg, state_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic                abort_reg, abort_next;
  logic                write_reg;
  logic                err_reg;
  logic [ADDR_W-3:0]   addr_reg;
  logic [WIDTH-1:0]    wdata_reg;
  logic [WIDTH-1:0]    prdata_reg;

  logic setup;
  logic err_now;
  logic wr_strobe, rd_strobe, ready;

  assign setup = psel & ~penable;

  // Every illegal access is decided at setup so the strobe can be suppressed.
  logic misaligned, out_of_range, ro_write, strb_bad, priv_bad;
  assign misaligned   = |paddr[1:0];
  assign out_of_range = paddr > MAX_ADDR;
  assign ro_write     = pwrite && (paddr == ADDR_W'('h080) || paddr == ADDR_W'('h08C) ||
                                   paddr == ADDR_W'('h090));
  assign strb_bad     = pwrite && (pstrb != '1);

`ifdef DMA_APB_PROT_CHECK_EN
  logic unused_prot;
  assign priv_bad    = ~pprot[0];
  assign unused_prot = ^pprot[2:1];
`else
  logic unused_prot;
  assign priv_bad    = 1'b0;
  assign unused_prot = ^pprot;
`endif

  assign err_now = misaligned | out_of_range | ro_write | strb_bad | priv_bad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      abort_reg  <= 1'b0;
      write_reg  <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      prdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      abort_reg <= abort_next;
      if (state_reg == IDLE && setup) begin
        write_reg <= pwrite;
        err_reg   <= err_now;
        addr_reg  <= paddr[ADDR_W-1:2];
        wdata_reg <= pwdata;
      end
      // Writes and errored transfers leave zero on prdata.
      if (state_reg == STROBE)
        prdata_reg <= rd_strobe ? cfg_rdata : '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    abort_next = abort_reg;
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        if (setup)
          state_next = STROBE;
      end
      STROBE: begin
        wr_strobe = write_reg & ~err_reg;
        rd_strobe = ~write_reg & ~err_reg;
        if (!psel)
          abort_next = 1'b1;
        if (EXTRA_WAIT > 0) begin
          state_next = WAIT;
          cnt_next   = WAIT_LOAD;
        end else begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (!psel)
          abort_next = 1'b1;
        if (cnt_reg == 3'd0)
          state_next = RESP;
        else
          cnt_next = cnt_reg - 3'd1;
      end
      RESP: begin
        // A master that dropped psel mid-transfer gets no completion.
        ready      = ~abort_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pready    = ready;
  assign pslverr   = ready & err_reg;
  assign prdata    = prdata_reg;
  assign cfg_wr_en = wr_strobe;
  assign cfg_rd_en = rd_strobe;
  assign cfg_addr  = WIDTH'({addr_reg, 2'b00});
  assign cfg_wdata = wdata_reg;

endmodule

// File: doc/dma_apb_cfg_slave.md
Name: dma_apb_cfg_slave

Overview:
- APB3/APB4 completer that fronts the DMA channel configuration register bank.
- Converts APB setup/access phases into single-cycle cfg_wr_en/cfg_rd_en strobes with a word-aligned byte address and write data.
- Captures returned read data and completes with PREADY/PSLVERR.
- Sits between the system APB interconnect and the channel register bank; the register bank's strobes, address and data inputs are driven only by this block.

Parameters:
- WIDTH, 32, data width of PWDATA/PRDATA and the cfg data buses.
- ADDR_W, 12, width of PADDR.
- MAX_ADDR, 12'h090, highest valid word-aligned register byte offset.
- EXTRA_WAIT, 0, additional wait cycles (0..7) inserted before PREADY.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  WIDTH  write data.
- pstrb  in  WIDTH/8  write byte strobes.
- pprot  in  3  protection type (used only with the optional feature).
- prdata  out  WIDTH  read data, registered.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid only while pready=1.
- cfg_wr_en  out  1  single-cycle write strobe to the register bank.
- cfg_rd_en  out  1  single-cycle read strobe to the register bank.
- cfg_addr  out  WIDTH  word-aligned byte address, zero-extended from ADDR_W.
- cfg_wdata  out  WIDTH  write data to the register bank.
- cfg_rdata  in  WIDTH  combinational read data from the register bank, valid while cfg_rd_en=1.

Behaviour:
- Reset: resetn asynchronous, active-low; clock clk. All outputs reset to 0; FSM goes to IDLE; the wait counter clears.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - On psel=1 and penable=0 (setup phase), register pwrite, paddr, pwdata, pstrb and pprot.
  - Evaluate the error condition, register it as err_q, and go to STROBE.
- STROBE (first access cycle):
  - If err_q=0: drive cfg_wr_en or cfg_rd_en high for exactly this cycle, with cfg_addr = {paddr_q[ADDR_W-1:2],2'b00} and cfg_wdata = pwdata_q.
  - On a read, capture cfg_rdata into the prdata register at the end of this cycle.
  - If err_q=1: assert no strobe and load prdata with 0.
  - pready=0. Next state is WAIT if EXTRA_WAIT>0, else RESP.
- WAIT: count down EXTRA_WAIT cycles with pready=0, then go to RESP.
- RESP:
  - pready=1 and pslverr=err_q for exactly one cycle; prdata is held valid (0 on writes and errors).
  - Next state is IDLE.
  - A new setup phase can begin on the cycle after RESP, so back-to-back transfers need no idle cycle.
- Nominal latency: write/read completes with pready on the 2nd access cycle (one wait state) when EXTRA_WAIT=0.
- Error conditions, checked at setup:
  - paddr[1:0] != 0.
  - paddr > MAX_ADDR.
  - Write to a read-only offset: 0x80, 0x8C or 0x90.
  - Write with pstrb != all-ones; the register bank has no byte enables.
  - Reads ignore pstrb.
- Erroneous transfers never produce a strobe, so no register-bank side effects occur.
- Protocol violation: if psel drops while in STROBE or WAIT, complete the internal sequence (a strobe already issued is not retracted), suppress pready, and return to IDLE.
- penable=1 in IDLE without a preceding setup phase is ignored.
- Reset mid-transfer: any strobe is immediately deasserted and no pready is issued.
- cfg_wr_en and cfg_rd_en are never high in the same cycle.

Optional Feature:
- Macro: DMA_APB_PROT_CHECK_EN.
- When defined, a transfer with pprot[0]=0 (unprivileged) is an additional error condition: pslverr=1, no strobe, prdata=0.
- When undefined, pprot is ignored (unused input) and unprivileged accesses behave as privileged ones.

Test Plan:
- Write 0x10 = 32'hA5A5_0001 with pstrb=4'hF -> cfg_wr_en one cycle, cfg_addr=0x10, cfg_wdata=32'hA5A5_0001; pready on the 2nd access cycle; pslverr=0.
- Read 0x10 with the bank returning 32'hA5A5_0001 -> cfg_rd_en one cycle; prdata=32'hA5A5_0001 with pready=1, pslverr=0.
- Error transfers, each expecting pslverr=1, no strobe, prdata=0 on reads:
  - write to 0x8C;
  - read of 0x0A (misaligned);
  - read of 0x94 (out of range);
  - write to 0x0C with pstrb=4'h3.
- Back-to-back write 0x20 then read 0x20 with no idle cycle between them, EXTRA_WAIT=3 -> each transfer has pready low for 4 access cycles; strobes are separated; read returns the written value.
- Assert resetn low during STROBE of a write -> cfg_wr_en, pready and pslverr go to 0 immediately; after reset release the next transfer completes normally.
- With DMA_APB_PROT_CHECK_EN defined, read 0x00 with pprot=3'b000 -> pslverr=1, no cfg_rd_en; with pprot=3'b001 -> normal read.
